// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The slave modport is the cache. The master modport is its environment: the fetch unit plus the fill memory.
interface icache_dm_if;
    logic        fetch_ic_req;
    logic [31:2] fetch_ic_addr;
    logic        fetch_ic_flush;
    logic        fetch_ic_inval;
    logic        icache_ready;
    logic        icache_valid;
    logic        icache_error;
    logic [31:0] icache_data;
    logic        ic_mem_req;
    logic [31:2] ic_mem_addr;
    logic        mem_ic_gnt;
    logic        mem_ic_valid;
    logic        mem_ic_error;
    logic [31:0] mem_ic_data;

    modport master (
        output fetch_ic_req, fetch_ic_addr, fetch_ic_flush, fetch_ic_inval,
        output mem_ic_gnt, mem_ic_valid, mem_ic_error, mem_ic_data,
        input  icache_ready, icache_valid, icache_error, icache_data,
        input  ic_mem_req, ic_mem_addr
    );

    modport slave (
        input  fetch_ic_req, fetch_ic_addr, fetch_ic_flush, fetch_ic_inval,
        input  mem_ic_gnt, mem_ic_valid, mem_ic_error, mem_ic_data,
        output icache_ready, icache_valid, icache_error, icache_data,
        output ic_mem_req, ic_mem_addr
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: two-stage hit pipeline (accept, lookup, respond)
// with a blocking line-fill miss engine.
module icache_dm #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input logic        clk,
    input logic        rst_n,
    icache_dm_if.slave bus
);
    localparam int OFFB = $clog2(LINE_WORDS);
    localparam int IDXB = $clog2(SETS);
    localparam int TAGB = 30 - OFFB - IDXB;

    typedef enum logic [1:0] {IDLE, MREQ, FILL, RESP} state_t;

    state_t state, state_nx;

    logic [SETS-1:0] line_valid;
    logic [TAGB-1:0] tag_mem  [SETS];
    logic [31:0]     data_mem [SETS*LINE_WORDS];

    logic        s1_valid;
    logic [31:2] s1_addr;
    logic        s2_valid;
    logic [31:0] s2_data;

    logic [31:2]     miss_addr;
    logic [OFFB-1:0] beat;
    logic            fill_err;
    logic            inval_seen;
    logic            resp_kill;
    logic [31:0]     fill_word;
    logic            ready_en;

    logic [OFFB-1:0] s1_off, miss_off;
    logic [IDXB-1:0] s1_idx, miss_idx;
    logic [TAGB-1:0] s1_tag, miss_tag;
    logic            hit, lookup_miss, start_miss, last_beat, accept, resp_fire;

    assign s1_off   = s1_addr[OFFB+1:2];
    assign s1_idx   = s1_addr[OFFB+IDXB+1:OFFB+2];
    assign s1_tag   = s1_addr[31:OFFB+IDXB+2];
    assign miss_off = miss_addr[OFFB+1:2];
    assign miss_idx = miss_addr[OFFB+IDXB+1:OFFB+2];
    assign miss_tag = miss_addr[31:OFFB+IDXB+2];

    assign hit         = line_valid[s1_idx] && (tag_mem[s1_idx] == s1_tag);
    assign lookup_miss = s1_valid && !hit;
    // A flush in the miss-detect cycle kills the request, so no fill is started for it.
    assign start_miss  = (state == IDLE) && lookup_miss && !bus.fetch_ic_flush;
    assign last_beat   = (state == FILL) && bus.mem_ic_valid && (beat == OFFB'(LINE_WORDS - 1));
    assign accept      = bus.fetch_ic_req && bus.icache_ready;
    assign resp_fire   = (state == RESP) && !resp_kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_miss) state_nx = MREQ;
            MREQ:    if (bus.mem_ic_gnt) state_nx = FILL;
            FILL:    if (last_beat) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.icache_ready = ready_en && (state == IDLE) && !lookup_miss
                           && !(bus.fetch_ic_req && bus.fetch_ic_flush);
        bus.icache_valid = s2_valid || resp_fire;
        bus.icache_error = resp_fire && fill_err;
        bus.icache_data  = '0;
        if (s2_valid) begin
            bus.icache_data = s2_data;
        end else if (resp_fire && !fill_err) begin
            bus.icache_data = fill_word;
        end
        bus.ic_mem_req  = (state == MREQ);
        bus.ic_mem_addr = {miss_tag, miss_idx, {OFFB{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            line_valid <= '0;
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            miss_addr  <= '0;
            beat       <= '0;
            fill_err   <= 1'b0;
            inval_seen <= 1'b0;
            resp_kill  <= 1'b0;
            fill_word  <= '0;
        end else begin
            ready_en <= 1'b1;
            s1_valid <= accept;
            if (accept) s1_addr <= bus.fetch_ic_addr;
            s2_valid <= s1_valid && hit && !bus.fetch_ic_flush;
            s2_data  <= data_mem[{s1_idx, s1_off}];

            // The victim line is dropped up front so a partial fill can never hit under its old tag.
            if (start_miss) begin
                miss_addr          <= s1_addr;
                beat               <= '0;
                fill_err           <= 1'b0;
                inval_seen         <= 1'b0;
                resp_kill          <= 1'b0;
                line_valid[s1_idx] <= 1'b0;
            end

            if (state == MREQ || state == FILL) begin
                if (bus.fetch_ic_flush) resp_kill <= 1'b1;
                if (bus.fetch_ic_inval) inval_seen <= 1'b1;
            end

            if (state == FILL && bus.mem_ic_valid) begin
                beat <= beat + OFFB'(1);
                if (beat == miss_off) fill_word <= bus.mem_ic_data;
                if (bus.mem_ic_error) fill_err <= 1'b1;
                if (last_beat && !fill_err && !bus.mem_ic_error && !inval_seen && !bus.fetch_ic_inval) begin
                    line_valid[miss_idx] <= 1'b1;
                end
            end

            if (bus.fetch_ic_inval) line_valid <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL && bus.mem_ic_valid) begin
            data_mem[{miss_idx, beat}] <= bus.mem_ic_data;
        end
        if (last_beat) begin
            tag_mem[miss_idx] <= miss_tag;
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: a line-level cache model plus response queue, checked every cycle,
// with literal expectations on the key responses.
module tb_icache_dm;
    localparam int SETS = 64;
    localparam int LW   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    bit          model_valid [SETS];
    logic [21:0] model_tag   [SETS];

    icache_dm_if bus();

    icache_dm #(.SETS(SETS), .LINE_WORDS(LW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Backing memory: every word holds its own word address plus 0x90.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {2'b00, a} + 32'h90;
    endfunction

    function automatic int idx_of(input logic [29:0] a);
        return int'(a[7:2]);
    endfunction

    function automatic logic [21:0] tag_of(input logic [29:0] a);
        return a[29:8];
    endfunction

    function automatic bit model_hit(input logic [29:0] a);
        return model_valid[idx_of(a)] && (model_tag[idx_of(a)] == tag_of(a));
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) model_valid[s] = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one request in the current cycle; the cache must take it.
    task automatic issue_one(input logic [29:0] a);
        exp_t e;
        bus.fetch_ic_req  = 1'b1;
        bus.fetch_ic_addr = a;
        @(negedge clk);
        chk("ready_accept", {31'd0, bus.icache_ready}, 32'd1);
        if (model_hit(a)) begin
            e.cyc  = cyc + 2;
            e.data = mem_word(a);
            e.err  = 1'b0;
            exp_q.push_back(e);
        end else begin
            model_valid[idx_of(a)] = 1'b0;
        end
        step();
        bus.fetch_ic_req = 1'b0;
    endtask

    task automatic serve_fill(input logic [29:0] a, input int err_beat, input int flush_beat,
                              input bit inval_last, input int reset_after);
        logic [29:0] line;
        int          n;
        bit          err;
        exp_t        e;
        line = {a[29:2], 2'b00};
        err  = 1'b0;
        n    = 0;
        @(negedge clk);
        while (!bus.ic_mem_req && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("mem_req_raised", {31'd0, bus.ic_mem_req}, 32'd1);
        if (!bus.ic_mem_req) return;
        chk("mem_addr", {2'b00, bus.ic_mem_addr}, {2'b00, line});
        step();
        bus.mem_ic_valid = 1'b1;
        bus.mem_ic_data  = 32'hDEADBEEF;
        @(negedge clk);
        chk("mem_req_hold", {31'd0, bus.ic_mem_req}, 32'd1);
        chk("mem_addr_hold", {2'b00, bus.ic_mem_addr}, {2'b00, line});
        step();
        bus.mem_ic_valid = 1'b0;
        bus.mem_ic_gnt   = 1'b1;
        step();
        bus.mem_ic_gnt = 1'b0;
        for (int i = 0; i < LW; i++) begin
            if (i == reset_after) begin
                bus.mem_ic_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("rst_valid", {31'd0, bus.icache_valid}, 32'd0);
                chk("rst_mem_req", {31'd0, bus.ic_mem_req}, 32'd0);
                chk("rst_mem_addr", {2'b00, bus.ic_mem_addr}, 32'd0);
                model_clear();
                return;
            end
            bus.mem_ic_valid   = 1'b1;
            bus.mem_ic_data    = mem_word(line + 30'(i));
            bus.mem_ic_error   = (i == err_beat);
            bus.fetch_ic_flush = (i == flush_beat);
            bus.fetch_ic_inval = (i == LW - 1) && inval_last;
            if (i == err_beat) err = 1'b1;
            if (i == LW - 1) begin
                if (!err && !inval_last) begin
                    model_valid[idx_of(a)] = 1'b1;
                    model_tag[idx_of(a)]   = tag_of(a);
                end
                if (inval_last) model_clear();
                if (flush_beat < 0) begin
                    e.cyc  = cyc + 1;
                    e.data = err ? 32'h0 : mem_word(a);
                    e.err  = err;
                    exp_q.push_back(e);
                end
            end
            step();
        end
        bus.mem_ic_valid   = 1'b0;
        bus.mem_ic_error   = 1'b0;
        bus.fetch_ic_flush = 1'b0;
        bus.fetch_ic_inval = 1'b0;
    endtask

    // Miss on a, with a second request offered in the miss-detect cycle, then serve the fill.
    // Returns in the response cycle.
    task automatic do_miss(input logic [29:0] a, input int err_beat, input int flush_beat,
                           input bit inval_last, input int reset_after);
        issue_one(a);
        bus.fetch_ic_req  = 1'b1;
        bus.fetch_ic_addr = a ^ 30'h1;
        @(negedge clk);
        chk("ready_miss_detect", {31'd0, bus.icache_ready}, 32'd0);
        step();
        bus.fetch_ic_req = 1'b0;
        serve_fill(a, err_beat, flush_beat, inval_last, reset_after);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_valid", {31'd0, bus.icache_valid}, 32'd0);
            chk("reset_error", {31'd0, bus.icache_error}, 32'd0);
            chk("reset_data", bus.icache_data, 32'd0);
            chk("reset_mem_req", {31'd0, bus.ic_mem_req}, 32'd0);
            chk("reset_mem_addr", {2'b00, bus.ic_mem_addr}, 32'd0);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("resp_missing", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("resp_valid", {31'd0, bus.icache_valid}, 32'd1);
                chk("resp_data", bus.icache_data, exp_q[0].data);
                chk("resp_error", {31'd0, bus.icache_error}, {31'd0, exp_q[0].err});
                void'(exp_q.pop_front());
            end else begin
                chk("no_resp_valid", {31'd0, bus.icache_valid}, 32'd0);
                chk("no_resp_error", {31'd0, bus.icache_error}, 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fetch_ic_req   = 1'b0;
        bus.fetch_ic_addr  = '0;
        bus.fetch_ic_flush = 1'b0;
        bus.fetch_ic_inval = 1'b0;
        bus.mem_ic_gnt     = 1'b0;
        bus.mem_ic_valid   = 1'b0;
        bus.mem_ic_error   = 1'b0;
        bus.mem_ic_data    = '0;
        model_clear();

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", {31'd0, bus.icache_ready}, 32'd1);
        step();

        // Cold miss on word 0x10.
        do_miss(30'h10, -1, -1, 1'b0, -1);
        chk("cold_valid", {31'd0, bus.icache_valid}, 32'd1);
        chk("cold_data", bus.icache_data, 32'hA0);
        chk("cold_error", {31'd0, bus.icache_error}, 32'd0);
        step();

        // Back-to-back hits on the whole line.
        for (int i = 0; i < LW; i++) begin
            issue_one(30'h10 + 30'(i));
            if (i >= 1) chk("stream_data", bus.icache_data, 32'hA0 + 32'(i - 1));
        end
        step();
        chk("stream_last", bus.icache_data, 32'hA3);
        step();

        // Conflict on the same index, then the original line misses again.
        do_miss(30'h10 + 30'(SETS * LW), -1, -1, 1'b0, -1);
        chk("conflict_data", bus.icache_data, 32'h1A0);
        step();
        do_miss(30'h10, -1, -1, 1'b0, -1);
        chk("conflict_back_data", bus.icache_data, 32'hA0);
        step();

        // Error on beat 2 of a miss to offset 1; retry must refill.
        do_miss(30'h21, 2, -1, 1'b0, -1);
        chk("err_valid", {31'd0, bus.icache_valid}, 32'd1);
        chk("err_flag", {31'd0, bus.icache_error}, 32'd1);
        chk("err_data", bus.icache_data, 32'd0);
        step();
        do_miss(30'h21, -1, -1, 1'b0, -1);
        chk("err_retry_data", bus.icache_data, 32'hB1);
        chk("err_retry_flag", {31'd0, bus.icache_error}, 32'd0);
        step();
        issue_one(30'h22);
        step();
        step();

        // Flush during the fill: no response, but the line is installed.
        do_miss(30'h31, -1, 1, 1'b0, -1);
        chk("flush_no_resp", {31'd0, bus.icache_valid}, 32'd0);
        step();
        issue_one(30'h31);
        step();
        chk("flush_line_hit", bus.icache_data, 32'hC1);
        step();

        // Request together with flush is refused.
        bus.fetch_ic_req   = 1'b1;
        bus.fetch_ic_addr  = 30'h31;
        bus.fetch_ic_flush = 1'b1;
        @(negedge clk);
        chk("ready_req_flush", {31'd0, bus.icache_ready}, 32'd0);
        step();
        bus.fetch_ic_req   = 1'b0;
        bus.fetch_ic_flush = 1'b0;
        step();
        step();

        // Flush in the lookup cycle of a hit drops its response.
        bus.fetch_ic_req  = 1'b1;
        bus.fetch_ic_addr = 30'h32;
        @(negedge clk);
        chk("ready_before_flush", {31'd0, bus.icache_ready}, 32'd1);
        step();
        bus.fetch_ic_req   = 1'b0;
        bus.fetch_ic_flush = 1'b1;
        step();
        bus.fetch_ic_flush = 1'b0;
        step();
        step();

        // Invalidate in the last-beat cycle: response still given, line not kept.
        do_miss(30'h41, -1, -1, 1'b1, -1);
        chk("inval_last_data", bus.icache_data, 32'hD1);
        step();
        do_miss(30'h41, -1, -1, 1'b0, -1);
        chk("inval_refill_data", bus.icache_data, 32'hD1);
        step();

        // Idle invalidate drops the freshly filled line.
        bus.fetch_ic_inval = 1'b1;
        model_clear();
        step();
        bus.fetch_ic_inval = 1'b0;
        do_miss(30'h41, -1, -1, 1'b0, -1);
        chk("idle_inval_refill", bus.icache_data, 32'hD1);
        step();

        // Reset after two fill beats abandons the fill.
        do_miss(30'h51, -1, -1, 1'b0, 2);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_midfill_reset", {31'd0, bus.icache_ready}, 32'd1);
        step();
        do_miss(30'h51, -1, -1, 1'b0, -1);
        chk("reset_refill_data", bus.icache_data, 32'hE1);
        step();

        repeat (4) step();
        while (exp_q.size() > 0) begin
            chk("resp_never_seen", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 The block SHALL have parameter SETS, default 64, meaning number of direct-mapped lines (power of 2, >=2).
REQ-002 The block SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per line (power of 2, >=2).
REQ-003 The block SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have ports: fetch_ic_req in 1 lookup request; fetch_ic_addr in [31:2] word address; fetch_ic_flush in 1 kill in-flight responses; fetch_ic_inval in 1 invalidate all lines.
REQ-006 The block SHALL have ports: icache_ready out 1 request accepted this cycle; icache_valid out 1 response strobe; icache_error out 1 response is a fetch fault; icache_data out 32 instruction word.
REQ-007 The block SHALL have ports: ic_mem_req out 1 line fill request; ic_mem_addr out [31:2] line-aligned word address; mem_ic_gnt in 1 fill request accepted; mem_ic_valid in 1 fill beat; mem_ic_error in 1 beat fault; mem_ic_data in 32 beat data.

Function
REQ-008 Address split SHALL be: offset = low log2(LINE_WORDS) bits of fetch_ic_addr, index = next log2(SETS) bits, tag = remaining upper bits.
REQ-009 A request SHALL be accepted in cycle T iff fetch_ic_req & icache_ready.
REQ-010 Pipeline: T+1 = lookup stage (stage-1 valid, tag compare against stored tag/valid bit); hit response SHALL assert icache_valid with the stored word in cycle T+2.
REQ-011 Back-to-back hits SHALL sustain one accepted request and one response per cycle.
REQ-012 icache_ready SHALL be 1 iff state==IDLE and the lookup stage does not hold a miss; a request offered in a miss-detect cycle is not accepted.
REQ-013 FSM states SHALL be IDLE, MREQ, FILL, RESP; a lookup-stage miss moves IDLE->MREQ at the next edge.
REQ-014 In MREQ, ic_mem_req SHALL be 1 with ic_mem_addr = {tag,index,offset 0}, held stable until mem_ic_gnt; on gnt, MREQ->FILL.
REQ-015 In FILL, each mem_ic_valid beat SHALL write data word k (k = beat count, 0..LINE_WORDS-1, in order) and increment k; beat count wraps to 0 after the last beat.
REQ-016 The requested word SHALL be captured when k equals the missed offset; mem_ic_error on any beat SHALL set a sticky fill-error flag.
REQ-017 On the last beat, tag written and valid bit set only if fill-error flag is 0 and no invalidate occurred during the fill; FILL->RESP.
REQ-018 In RESP, icache_valid SHALL be 1 for one cycle with icache_data = captured word and icache_error = fill-error flag; RESP->IDLE; error response returns icache_data = 0.
REQ-019 icache_error SHALL be 0 whenever icache_valid is 0 or response is a hit.
REQ-020 fetch_ic_flush SHALL clear stage-1 and stage-2 valids at the next edge (no response for requests accepted at or before the flush cycle) and SHALL suppress the RESP strobe of an in-progress miss; the fill itself still completes and installs the line.
REQ-021 fetch_ic_inval SHALL clear all valid bits at the next edge; an inval coinciding with a last-beat install wins (line not valid).
REQ-022 Simultaneous fetch_ic_req and fetch_ic_flush SHALL not accept the request (icache_ready forced 0 that cycle).
REQ-023 mem_ic_valid outside FILL SHALL be ignored.

Reset
REQ-024 rst_n low SHALL asynchronously set state IDLE, all valid bits 0, stage valids 0, beat count 0, fill-error 0.
REQ-025 During reset: icache_valid=0, icache_error=0, icache_data=0, ic_mem_req=0, ic_mem_addr=0; icache_ready=1 from the first edge after rst_n deasserts.
REQ-026 Reset asserted mid-fill SHALL abandon the fill with no line installed and no response.

Verification
REQ-027 Cold miss: req addr 0x40/4 word 0x10 -> ic_mem_req with ic_mem_addr word 0x10, gnt, 4 beats 0xA0..0xA3 -> icache_valid with data 0xA0, error 0.
REQ-028 Hit stream: after REQ-027, req words 0x10,0x11,0x12,0x13 in consecutive cycles -> valid in 4 consecutive cycles, data 0xA0..0xA3, first at T+2.
REQ-029 Conflict: req word 0x10+SETS*4 (same index, new tag) -> miss, refill, then word 0x10 misses again.
REQ-030 Error fill: beat 2 with mem_ic_error=1 on miss to offset 1 -> icache_valid=1, icache_error=1, data 0; repeat request misses again.
REQ-031 Flush/inval: flush during FILL -> no response, later same address hits; inval in last-beat cycle -> later same address misses.
REQ-032 Reset mid-FILL after 2 beats -> outputs 0 immediately, ready=1 after release, same address misses.
